// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
//   Groups the controller <-> datapath/memory signals.
//   master : controller side (decode inputs in, control strobes out)
//   slave  : datapath/memory side (mirror of master)
//   Inputs to controller : op[5:0], funct[5:0], zero, mem_ready
//   Outputs of controller: mem_req, iord, memwrite, irwrite, pcen, pcsrc[1:0],
//                          regdst, memtoreg, regwrite, alusrca, alusrcb[1:0],
//                          alucontrol[2:0], illegal_op, fault, state[3:0]
// ---------------------------------------------------------------------------
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic       fault;
    logic [3:0] state;

    modport master (
        input  op, funct, zero, mem_ready,
        output mem_req, iord, memwrite, irwrite, pcen, pcsrc, regdst, memtoreg,
               regwrite, alusrca, alusrcb, alucontrol, illegal_op, fault, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  mem_req, iord, memwrite, irwrite, pcen, pcsrc, regdst, memtoreg,
               regwrite, alusrca, alusrcb, alucontrol, illegal_op, fault, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//   Control FSM for a multicycle datapath sharing one instruction+data memory.
//   Sequences fetch/decode/execute/memory/writeback, drives all datapath
//   selects and enables, stalls memory states until mem_ready, and latches a
//   sticky fault when a memory access waits TIMEOUT consecutive cycles.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-low reset
//     bus   : multicycle_controller_if.master (decode inputs, control outputs)
//   Parameters:
//     TIMEOUT      : wait cycles in a memory state before fault (1..255)
//     SUPPORT_ADDI : 1 decodes addi, 0 treats it as an illegal opcode
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned TIMEOUT      = 16,
    parameter bit          SUPPORT_ADDI = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       bus
);

    typedef enum logic [3:0] {
        RST0    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADR  = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXECUTE = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        ADDIEX  = 4'd10,
        ADDIWB  = 4'd11,
        JUMP    = 4'd12,
        FAULT   = 4'd13
    } state_t;

    localparam logic [7:0] W_LIMIT = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait;
    logic       w_mem_wait;

    // A wait cycle is a memory state whose access has not completed yet.
    assign w_mem_wait = ((r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR))
                        && !bus.mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RST0;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait <= '0;
        end else if (w_next != r_state) begin
            r_wait <= '0;
        end else if (w_mem_wait) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.mem_req    = 1'b0;
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.pcen       = 1'b0;
        bus.pcsrc      = 2'b00;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.alucontrol = 3'b000;
        bus.illegal_op = 1'b0;
        bus.fault      = 1'b0;
        bus.state      = r_state;

        unique case (r_state)
            RST0: w_next = FETCH;
            FETCH: begin
                bus.mem_req    = 1'b1;
                bus.alusrcb    = 2'b01;
                bus.alucontrol = 3'b010;
                if (bus.mem_ready) begin
                    bus.irwrite = 1'b1;
                    bus.pcen    = 1'b1;
                    w_next      = DECODE;
                end
            end
            DECODE: begin
                bus.alusrcb    = 2'b11;
                bus.alucontrol = 3'b010;
                case (bus.op)
                    6'b100011, 6'b101011: w_next = MEMADR;
                    6'b000000:            w_next = EXECUTE;
                    6'b000100:            w_next = BRANCH;
                    6'b000010:            w_next = JUMP;
                    6'b001000: begin
                        if (SUPPORT_ADDI) begin
                            w_next = ADDIEX;
                        end else begin
                            bus.illegal_op = 1'b1;
                            w_next         = FETCH;
                        end
                    end
                    default: begin
                        bus.illegal_op = 1'b1;
                        w_next         = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = 3'b010;
                w_next         = (bus.op == 6'b101011) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
                if (bus.mem_ready) w_next = MEMWB;
            end
            MEMWB: begin
                bus.memtoreg = 1'b1;
                bus.regwrite = 1'b1;
                w_next       = FETCH;
            end
            MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.iord     = 1'b1;
                bus.memwrite = bus.mem_ready;
                if (bus.mem_ready) w_next = FETCH;
            end
            EXECUTE: begin
                bus.alusrca = 1'b1;
                w_next      = ALUWB;
                case (bus.funct)
                    6'b100000: bus.alucontrol = 3'b010;
                    6'b100010: bus.alucontrol = 3'b110;
                    6'b100100: bus.alucontrol = 3'b000;
                    6'b100101: bus.alucontrol = 3'b001;
                    6'b101010: bus.alucontrol = 3'b111;
                    default: begin
                        bus.illegal_op = 1'b1;
                        w_next         = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                bus.regdst   = 1'b1;
                bus.regwrite = 1'b1;
                w_next       = FETCH;
            end
            BRANCH: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = 3'b110;
                bus.pcsrc      = 2'b01;
                bus.pcen       = bus.zero;
                w_next         = FETCH;
            end
            ADDIEX: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = 3'b010;
                w_next         = ADDIWB;
            end
            ADDIWB: begin
                bus.regwrite = 1'b1;
                w_next       = FETCH;
            end
            JUMP: begin
                bus.pcsrc = 2'b10;
                bus.pcen  = 1'b1;
                w_next    = FETCH;
            end
            FAULT: bus.fault = 1'b1;
            default: w_next = RST0;
        endcase

        // The TIMEOUT-th consecutive wait cycle diverts straight to FAULT.
        if (w_mem_wait && (r_wait == W_LIMIT)) begin
            w_next = FAULT;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//   Expands each instruction into its expected per-cycle control words
//   (including memory wait cycles) and plays them against the controller.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int unsigned TIMEOUT = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if bus();

    multicycle_controller #(
        .TIMEOUT      (TIMEOUT),
        .SUPPORT_ADDI (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] obs;
    assign obs = {bus.mem_req, bus.iord, bus.memwrite, bus.irwrite, bus.pcen, bus.pcsrc,
                  bus.regdst, bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb,
                  bus.alucontrol, bus.illegal_op, bus.fault};

    logic [17:0] q_exp[$];
    logic        q_mr[$];
    logic        q_z[$];
    logic [5:0]  q_op[$];
    logic [5:0]  q_fn[$];
    string       q_tag[$];
    logic [5:0]  cur_op = '0;
    logic [5:0]  cur_fn = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] cw(input logic mr, io, mw, ir, pe, input logic [1:0] ps,
                                       input logic rd, m2r, rw, sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic il, ft);
        return {mr, io, mw, ir, pe, ps, rd, m2r, rw, sa, sb, ac, il, ft};
    endfunction

    // Expected control word for each step of an instruction.
    function automatic logic [17:0] f_fetch(input logic go);
        return cw(1, 0, 0, go, go, 2'b00, 0, 0, 0, 0, 2'b01, 3'b010, 0, 0);
    endfunction
    function automatic logic [17:0] f_dec(input logic il);
        return cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 3'b010, il, 0);
    endfunction
    function automatic logic [17:0] f_addr();
        return cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 3'b010, 0, 0);
    endfunction
    function automatic logic [17:0] f_memrd();
        return cw(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [17:0] f_memwb();
        return cw(0, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [17:0] f_memwr(input logic go);
        return cw(1, 1, go, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [17:0] f_exec(input logic [2:0] ac, input logic il);
        return cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, ac, il, 0);
    endfunction
    function automatic logic [17:0] f_aluwb();
        return cw(0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [17:0] f_branch(input logic z);
        return cw(0, 0, 0, 0, z, 2'b01, 0, 0, 0, 1, 2'b00, 3'b110, 0, 0);
    endfunction
    function automatic logic [17:0] f_addiwb();
        return cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [17:0] f_jump();
        return cw(0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 2'b00, 3'b000, 0, 0);
    endfunction
    function automatic logic [17:0] f_fault();
        return cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1);
    endfunction

    function automatic logic legal_op(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction
    function automatic logic legal_fn(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction
    function automatic logic [2:0] fn_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    task automatic push(input string tag, input logic [17:0] w, input logic mr, input logic z);
        q_tag.push_back(tag);
        q_exp.push_back(w);
        q_mr.push_back(mr);
        q_z.push_back(z);
        q_op.push_back(cur_op);
        q_fn.push_back(cur_fn);
    endtask

    // mem_ready/zero are don't-cares here, so they are randomized.
    task automatic push_r(input string tag, input logic [17:0] w);
        push(tag, w, 1'($urandom), 1'($urandom));
    endtask

    task automatic push_fetch(input int waits);
        for (int i = 0; i < waits; i++) push("fetch_wait", f_fetch(1'b0), 1'b0, 1'($urandom));
        push("fetch", f_fetch(1'b1), 1'b1, 1'($urandom));
    endtask

    // kind: 0 lw, 1 sw, 2 R, 3 beq, 4 addi, 5 j, 6 illegal op
    task automatic gen_instr(input int kind, input int fw, input int mw,
                             input logic [5:0] fn, input logic z);
        cur_fn = fn;
        case (kind)
            0: cur_op = 6'b100011;
            1: cur_op = 6'b101011;
            2: cur_op = 6'b000000;
            3: cur_op = 6'b000100;
            4: cur_op = 6'b001000;
            5: cur_op = 6'b000010;
            default: begin
                cur_op = 6'($urandom);
                while (legal_op(cur_op)) cur_op = 6'($urandom);
            end
        endcase
        push_fetch(fw);
        push_r("decode", f_dec(kind == 6));
        case (kind)
            0: begin
                push_r("lw_addr", f_addr());
                for (int i = 0; i < mw; i++) push("lw_rd_wait", f_memrd(), 1'b0, 1'($urandom));
                push("lw_rd", f_memrd(), 1'b1, 1'($urandom));
                push_r("lw_wb", f_memwb());
            end
            1: begin
                push_r("sw_addr", f_addr());
                for (int i = 0; i < mw; i++) push("sw_wait", f_memwr(1'b0), 1'b0, 1'($urandom));
                push("sw_wr", f_memwr(1'b1), 1'b1, 1'($urandom));
            end
            2: begin
                if (legal_fn(fn)) begin
                    push_r("r_exec", f_exec(fn_alu(fn), 1'b0));
                    push_r("r_wb", f_aluwb());
                end else begin
                    push_r("r_illegal", f_exec(3'b000, 1'b1));
                end
            end
            3: push("branch", f_branch(z), 1'($urandom), z);
            4: begin
                push_r("addi_ex", f_addr());
                push_r("addi_wb", f_addiwb());
            end
            5: push_r("jump", f_jump());
            default: ;
        endcase
    endtask

    task automatic play();
        while (q_exp.size() > 0) begin
            @(posedge clk);
            #1;
            bus.mem_ready = q_mr.pop_front();
            bus.zero      = q_z.pop_front();
            bus.op        = q_op.pop_front();
            bus.funct     = q_fn.pop_front();
            @(negedge clk);
            check(q_tag.pop_front(), 32'(obs), 32'(q_exp.pop_front()));
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("reset_out", 32'(obs), 32'd0);
            check("reset_state", 32'(bus.state), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst0_out", 32'(obs), 32'd0);
        check("rst0_state", 32'(bus.state), 32'd0);
    endtask

    function automatic logic [5:0] rand_fn(input logic legal);
        logic [5:0] fn;
        logic [5:0] tbl [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        if (legal) return tbl[$urandom_range(0, 4)];
        fn = 6'($urandom);
        while (legal_fn(fn)) fn = 6'($urandom);
        return fn;
    endfunction

    initial begin
        bus.op        = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        do_reset(3);

        // Directed instructions, no wait states unless stated.
        gen_instr(0, 0, 0, 6'b000000, 1'b0);
        gen_instr(2, 0, 0, 6'b101010, 1'b0);
        gen_instr(2, 0, 0, 6'b000001, 1'b0);
        gen_instr(3, 0, 0, 6'b000000, 1'b1);
        gen_instr(3, 0, 0, 6'b000000, 1'b0);
        gen_instr(5, 0, 0, 6'b000000, 1'b0);
        gen_instr(1, 0, 5, 6'b000000, 1'b0);
        gen_instr(4, 0, 0, 6'b000000, 1'b0);
        gen_instr(6, 0, 0, 6'b000000, 1'b0);
        // One short of the watchdog limit must not fault.
        gen_instr(0, TIMEOUT - 1, TIMEOUT - 1, 6'b000000, 1'b0);
        play();

        // Random instruction stream with short wait states.
        for (int n = 0; n < 80; n++) begin
            int k;
            k = $urandom_range(0, 6);
            gen_instr(k, $urandom_range(0, 3), $urandom_range(0, 3),
                      (k == 2) ? rand_fn($urandom_range(0, 3) != 0) : 6'($urandom),
                      1'($urandom));
        end
        play();

        // Watchdog in FETCH: fault is sticky regardless of later mem_ready.
        for (int i = 0; i < int'(TIMEOUT); i++) push("wd_fetch_wait", f_fetch(1'b0), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_r("fault_sticky", f_fault());
        play();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("fault_async_clear", 32'(obs), 32'd0);
        check("fault_async_state", 32'(bus.state), 32'd0);
        do_reset(2);

        // Watchdog in MEMRD.
        cur_op = 6'b100011;
        push_fetch(0);
        push_r("decode", f_dec(1'b0));
        push_r("lw_addr", f_addr());
        for (int i = 0; i < int'(TIMEOUT); i++) push("wd_rd_wait", f_memrd(), 1'b0, 1'b0);
        push_r("fault_rd", f_fault());
        play();
        do_reset(1);

        // Reset falling mid-store must suppress memwrite even with mem_ready high.
        cur_op = 6'b101011;
        push_fetch(1);
        push_r("decode", f_dec(1'b0));
        push_r("sw_addr", f_addr());
        for (int i = 0; i < 3; i++) push("sw_wait", f_memwr(1'b0), 1'b0, 1'b0);
        play();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check("midreset_out", 32'(obs), 32'd0);
        do_reset(1);
        gen_instr(5, 0, 0, 6'b000000, 1'b0);
        play();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
